// File: rtl/uart_rx_arb_pkg.sv
// Shared definitions for the UART receive arbiter: the output-register FSM
// encoding and the width of the per-channel byte counters.
// Optional feature macro: UART_RX_ARB_CNT_EN (per-channel byte counters).
package uart_rx_arb_pkg;

  // EMPTY: output register holds nothing; FULL: o_data/o_chan are valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/uart_rx_arb_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from rr_ptr, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (request vector), rr_ptr (search start), grant_valid (any request),
//        grant_idx (chosen channel, 0 when grant_valid=0).
module rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  rr_ptr,
  output logic           grant_valid,
  output logic [CW-1:0]  grant_idx
);

  logic [CW-1:0] idx;

  // Scan from the farthest offset down to offset 0, so the request closest
  // to rr_ptr overwrites any later one and ends up as the winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_ptr) + k) % NCH);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_rx_arb.sv
// Round-robin arbiter merging NCH UART receive FIFOs into one byte stream.
// Latency: 1 cycle from a request in a load slot to o_valid; 1 byte/cycle sustained.
// Backpressure: o_ready=0 holds the output register and blocks further pops.
// Ports: clk, rst (sync, active-high), en, ch_mask, fifo_out/fifo_empty/fifo_read
//        (per-channel FIFO heads and pop strobes), o_data/o_chan/o_valid/o_ready
//        (output handshake), cnt_sel/cnt_out (byte-counter readback).
// Optional feature macro: UART_RX_ARB_CNT_EN enables per-channel 16-bit
// saturating byte counters; without it cnt_out is tied to 0.
module uart_rx_arb
  import uart_rx_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [8*NCH-1:0] fifo_out,
  input  logic [NCH-1:0]   fifo_empty,
  output logic [NCH-1:0]   fifo_read,
  output logic [7:0]       o_data,
  output logic [CW-1:0]    o_chan,
  output logic             o_valid,
  input  logic             o_ready,
  input  logic [CW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  arb_state_t     state, state_nxt;
  logic [CW-1:0]  rr_ptr;
  logic [NCH-1:0] req;
  logic           grant_valid;
  logic [CW-1:0]  grant_idx;
  logic           load;
  logic           grant;

  assign req = ~fifo_empty & ch_mask;

  rr_pick #(
    .NCH(NCH),
    .CW (CW)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A load slot exists when the output register is free or being drained this
  // cycle. The pop strobe is gated by rst so a reset cycle never consumes a byte.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    grant     = 1'b0;
    fifo_read = '0;
    load      = en && (state == EMPTY || o_ready);
    grant     = load && grant_valid && !rst;
    if (grant) begin
      fifo_read[grant_idx] = 1'b1;
    end
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (o_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign o_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
      o_chan <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      o_data <= fifo_out[8*grant_idx +: 8];
      o_chan <= grant_idx;
      rr_ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef UART_RX_ARB_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      cnt_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fifo_read[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
      cnt_out <= cnt[cnt_sel];
    end
  end
`else
  logic cnt_sel_unused;
  assign cnt_sel_unused = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_uart_rx_arb.sv
// Self-checking bench for uart_rx_arb (NCH=4). Channel FIFOs are modelled as
// byte queues; the reference model tracks the output register, round-robin
// pointer and byte counters directly from the arbitration rules.
module tb_uart_rx_arb;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  ch_mask;
  logic [31:0] fifo_out;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_read;
  logic [7:0]  o_data;
  logic [1:0]  o_chan;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_out;

  always #5 clk = ~clk;

  uart_rx_arb #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_mask   (ch_mask),
    .fifo_out  (fifo_out),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .o_data    (o_data),
    .o_chan    (o_chan),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  // Reference model state
  logic [7:0] fq [NCH][$];
  logic       m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;
  int         m_cnt [NCH];
  int         m_cnt_out;
  logic [3:0] rd_exp;
  logic [3:0] rd_obs;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [3:0] model_rd();
    logic [3:0] r;
    r = '0;
    if (rst || !en || (m_valid && !o_ready)) return r;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (ch_mask[c] && fq[c].size() > 0) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < NCH; i++) begin
      fifo_empty[i]     = (fq[i].size() == 0);
      fifo_out[8*i +: 8] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    fq[ch].push_back(b);
    drive_fifos();
  endtask

  // One clock: sample the pop strobe before the edge, advance the model at the
  // edge, refresh FIFO heads, and return at posedge+1 for output sampling.
  task automatic clk_step();
    #2;
    rd_obs = fifo_read;
    rd_exp = model_rd();
    @(posedge clk);
    if (rst) begin
      m_valid   = 1'b0;
      m_data    = 8'h00;
      m_chan    = 0;
      m_ptr     = 0;
      m_cnt_out = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else begin
      m_cnt_out = m_cnt[cnt_sel];
      if (rd_exp != 4'b0) begin
        int c;
        c = 0;
        for (int i = 0; i < NCH; i++) if (rd_exp[i]) c = i;
        m_data  = fq[c].pop_front();
        m_chan  = c;
        m_valid = 1'b1;
        m_ptr   = (c + 1) % NCH;
        if (m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
      end else if (m_valid && o_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    drive_fifos();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    en = 1'b1; ch_mask = 4'hF; o_ready = 1'b1;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() > 0 || m_valid) && budget < 60) begin
      clk_step();
      budget++;
    end
    if (budget >= 60) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: model still busy after %0d cycles (required idle)", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ch_mask = 4'hF; o_ready = 1'b0; cnt_sel = 2'd0;
    push(0, 8'hAA);
    push(3, 8'h55);
    clk_step();
    clk_step();
    n_checks++; if (rd_obs !== 4'b0000) begin n_fail++; $display("FAIL reset_fifo_read: got %b want 0000", rd_obs); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_o_data: got %h want 00", o_data); end
    n_checks++; if (o_chan !== 2'd0) begin n_fail++; $display("FAIL reset_o_chan: got %0d want 0", o_chan); end
    n_checks++; if (cnt_out !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_out: got %0d want 0", cnt_out); end
    for (int i = 0; i < NCH; i++) fq[i].delete();
    drive_fifos();
    rst = 1'b0;
  endtask

  task automatic test_rr_order();
    logic [7:0] ed;
    o_ready = 1'b1; en = 1'b1; ch_mask = 4'hF;
    push(0, 8'h10); push(1, 8'h21); push(2, 8'h32); push(3, 8'h43);
    for (int k = 0; k < 4; k++) begin
      clk_step();
      ed = 8'(16 + 17 * k);
      n_checks++; if (rd_obs !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_fifo_read[%0d]: got %b want %b", k, rd_obs, 4'(1 << k)); end
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rr_o_valid[%0d]: got %b want 1", k, o_valid); end
      n_checks++; if (o_chan !== 2'(k)) begin n_fail++; $display("FAIL rr_o_chan[%0d]: got %0d want %0d", k, o_chan, k); end
      n_checks++; if (o_data !== ed) begin n_fail++; $display("FAIL rr_o_data[%0d]: got %h want %h", k, o_data, ed); end
    end
    clk_step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_alternate();
    int seq [4];
    seq = '{1, 3, 1, 3};
    o_ready = 1'b1; en = 1'b1; ch_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      push(1, 8'($urandom));
      push(3, 8'($urandom));
    end
    for (int k = 0; k < 4; k++) begin
      clk_step();
      n_checks++; if (o_chan !== 2'(seq[k]) || o_valid !== 1'b1) begin n_fail++; $display("FAIL alt_chan[%0d]: got %0d valid %b want %0d valid 1", k, o_chan, o_valid, seq[k]); end
      n_checks++; if (o_data !== m_data) begin n_fail++; $display("FAIL alt_data[%0d]: got %h want %h", k, o_data, m_data); end
    end
    drain();
  endtask

  task automatic test_stall();
    en = 1'b1; ch_mask = 4'hF; o_ready = 1'b0;
    push(2, 8'h5A); push(2, 8'hC3); push(0, 8'h77);
    clk_step();
    n_checks++; if (o_valid !== 1'b1 || o_chan !== 2'(m_chan)) begin n_fail++; $display("FAIL stall_load: valid %b chan %0d want 1 chan %0d", o_valid, o_chan, m_chan); end
    for (int k = 0; k < 5; k++) begin
      clk_step();
      n_checks++; if (rd_obs !== 4'b0000) begin n_fail++; $display("FAIL stall_fifo_read[%0d]: got %b want 0000", k, rd_obs); end
      n_checks++; if (o_valid !== 1'b1 || o_data !== m_data || o_chan !== 2'(m_chan)) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid %b data %h chan %0d want 1 %h %0d", k, o_valid, o_data, o_chan, m_data, m_chan);
      end
    end
    drain();
  endtask

  task automatic test_mask();
    ch_mask = 4'b1101; en = 1'b1;
    for (int i = 0; i < NCH; i++) for (int j = 0; j < 3; j++) push(i, 8'($urandom));
    for (int k = 0; k < 16; k++) begin
      o_ready = 1'($urandom_range(0, 3) != 0);
      clk_step();
      n_checks++; if (rd_obs[1] !== 1'b0 || rd_obs !== rd_exp) begin n_fail++; $display("FAIL mask_fifo_read[%0d]: got %b want %b", k, rd_obs, rd_exp); end
      n_checks++; if (o_valid !== m_valid || (m_valid && (o_chan !== 2'(m_chan) || o_data !== m_data))) begin
        n_fail++; $display("FAIL mask_out[%0d]: valid %b chan %0d data %h want %b %0d %h", k, o_valid, o_chan, o_data, m_valid, m_chan, m_data);
      end
    end
    drain();
  endtask

  task automatic test_rst_stall();
    en = 1'b1; ch_mask = 4'hF; o_ready = 1'b0;
    push(2, 8'hE1);
    clk_step();
    clk_step();
    n_checks++; if (o_valid !== 1'b1 || o_chan !== 2'd2) begin n_fail++; $display("FAIL rststall_held: valid %b chan %0d want 1 chan 2", o_valid, o_chan); end
    rst = 1'b1;
    clk_step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rststall_valid: got %b want 0", o_valid); end
    rst = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < NCH; i++) push(i, 8'(8'hA0 + i));
    clk_step();
    n_checks++; if (o_chan !== 2'd0 || o_data !== 8'hA0 || rd_obs !== 4'b0001) begin
      n_fail++; $display("FAIL rststall_ptr: chan %0d data %h rd %b want 0 a0 0001", o_chan, o_data, rd_obs);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      int ch;
      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 1) == 1 && fq[ch].size() < 6) push(ch, 8'($urandom));
      en      = 1'($urandom_range(0, 7) != 0);
      ch_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      o_ready = 1'($urandom_range(0, 2) != 0);
      cnt_sel = 2'($urandom);
      clk_step();
      n_checks++; if (rd_obs !== rd_exp) begin n_fail++; $display("FAIL rand_fifo_read[%0d]: got %b want %b", k, rd_obs, rd_exp); end
      n_checks++; if (o_valid !== m_valid || (m_valid && (o_chan !== 2'(m_chan) || o_data !== m_data))) begin
        n_fail++; $display("FAIL rand_out[%0d]: valid %b chan %0d data %h want %b %0d %h", k, o_valid, o_chan, o_data, m_valid, m_chan, m_data);
      end
`ifdef UART_RX_ARB_CNT_EN
      n_checks++; if (cnt_out !== 16'(m_cnt_out)) begin n_fail++; $display("FAIL rand_cnt_out[%0d]: got %0d want %0d", k, cnt_out, m_cnt_out); end
`endif
    end
    drain();
  endtask

  task automatic test_counter();
`ifdef UART_RX_ARB_CNT_EN
    rst = 1'b1; cnt_sel = 2'd0;
    clk_step();
    rst = 1'b0; en = 1'b1; ch_mask = 4'hF; o_ready = 1'b1;
    push(2, 8'h01); push(2, 8'h02); push(2, 8'h03);
    for (int k = 0; k < 4; k++) clk_step();
    cnt_sel = 2'd2;
    clk_step();
    n_checks++; if (cnt_out !== 16'd3) begin n_fail++; $display("FAIL cnt_ch2: got %0d want 3", cnt_out); end
    cnt_sel = 2'd1;
    clk_step();
    n_checks++; if (cnt_out !== 16'd0) begin n_fail++; $display("FAIL cnt_ch1: got %0d want 0", cnt_out); end
`else
    cnt_sel = 2'd2;
    for (int i = 0; i < 3; i++) push(2, 8'($urandom));
    for (int k = 0; k < 4; k++) clk_step();
    n_checks++; if (cnt_out !== 16'd0) begin n_fail++; $display("FAIL cnt_tied: got %0d want 0", cnt_out); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ch_mask = 4'h0; o_ready = 1'b0; cnt_sel = 2'd0;
    m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0; m_cnt_out = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    drive_fifos();
    test_reset();
    test_rr_order();
    test_alternate();
    test_stall();
    test_mask();
    test_rst_stall();
    test_random();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
